apb_bridge_gen: RTL
===================

# apb_bridge_gen

Parametrised AHB-to-APB bridge: a single AHB slave port converting AHB-Lite transfers into APB (AMBA 5) SETUP/ACCESS cycles for `NUM_SLV` APB slaves. It integrates the address decode, the per-slave `psel` fan-out and the `prdata`/`pready`/`pslverr` return muxing. Beyond a fixed-slave bridge, it adds:
- a configurable slave count and address map,
- a two-cycle AHB ERROR response for `pslverr`, decode misses and timeouts,
- a per-access `pready` timeout,
- back-to-back transfer acceptance.

It sits between the AHB interconnect and the peripheral APB segment.

## Interface
Parameters:
- `NUM_SLV`, 12, number of APB slaves (1..16).
- `ADDR_W`, 32, `haddr`/`paddr` width.
- `DATA_W`, 32, AHB and APB data width.
- `SLV_BITS`, 12, log2 of the per-slave window in bytes (4 KB).
- `BASE_ADDR`, 32'h4000_0000, bridge base address. `haddr` bits above `SLV_BITS+IDX_W` must equal `BASE_ADDR` bits, where `IDX_W=$clog2(NUM_SLV)` (min 1).
- `TIMEOUT`, 256, maximum ACCESS cycles before abort; 0 disables the timeout.

Ports:
- `hclk` in 1 — clock; all logic on its rising edge.
- `hreset` in 1 — synchronous, active-high reset.
- `hsel` in 1 — bridge selected.
- `haddr` in `ADDR_W` — AHB address.
- `htrans` in 2 — transfer type.
- `hwrite` in 1 — 1 = write.
- `hready` in 1 — AHB bus ready.
- `hwdata` in `DATA_W` — write data.
- `hrdata` out `DATA_W` — read data.
- `hreadyout` out 1 — bridge ready.
- `hresp` out 1 — 0 OKAY, 1 ERROR.
- `psel` out `NUM_SLV` — one-hot slave select.
- `paddr` out `ADDR_W` — registered address.
- `penable` out 1 — ACCESS phase.
- `pwrite` out 1 — registered direction.
- `pwdata` out `DATA_W` — write data.
- `prdata` in `NUM_SLV*DATA_W` — slave `i` occupies bits `[i*DATA_W +: DATA_W]`.
- `pready` in `NUM_SLV` — per-slave ready.
- `pslverr` in `NUM_SLV` — per-slave error.

## Operation
- **Valid transfer:** `hsel & hready & htrans[1]` (NONSEQ/SEQ). IDLE/BUSY and unselected cycles are ignored and get a zero-wait OKAY.
- **Address-phase capture:** on a valid transfer, latch `haddr`→`paddr`, `hwrite`→`pwrite`, and index `idx = haddr[SLV_BITS +: IDX_W]`.
  - **Hit:** base match and `idx < NUM_SLV`.
  - **Miss:** otherwise.
- **FSM states:** IDLE, SETUP, ACCESS, ERR1, ERR2.
  - **IDLE:** `hreadyout=1`, `hresp=0`. Valid hit → SETUP. Valid miss → ERR1.
  - **SETUP:** `psel[idx]=1`, `penable=0`, `hreadyout=0`. Always → ACCESS. Clear the timeout counter.
  - **ACCESS:** `psel[idx]=1`, `penable=1`. Wait on `pready[idx]`; increment the counter each cycle `pready[idx]=0`.
    - `pready[idx]=1`, `pslverr[idx]=0`: `hreadyout=1`, `hresp=0`. On a read, `hrdata` = `prdata` slice `idx` in this cycle. Next state: SETUP if a new valid hit is presented this cycle, ERR1 if a valid miss, else IDLE.
    - `pready[idx]=1`, `pslverr[idx]=1`: `hreadyout=0`, `hresp=0` this cycle → ERR1.
    - Counter reaches `TIMEOUT-1` with `pready` low (`TIMEOUT!=0`): drop `psel`/`penable` next cycle → ERR1.
  - **ERR1:** `hresp=1`, `hreadyout=0`, `psel=0`, `penable=0`. → ERR2.
  - **ERR2:** `hresp=1`, `hreadyout=1`. Accepts a pipelined valid transfer (→ SETUP/ERR1), else → IDLE.
- **`pwdata`:**
  - Equals `hwdata` in SETUP/ACCESS of a write; the master holds `hwdata` stable while `hreadyout=0`.
  - Registered into `pwdata_q` at the end of SETUP and driven from `pwdata_q` in ACCESS.
  - 0 otherwise.
- **`hrdata`:** 0 except in the completing read cycle.
- **Select:** `psel` is never multi-hot; `penable` is only ever 1 while some `psel` bit is 1.

## Timing
- **Reset values** (sync, takes effect at the next edge):
  - state IDLE;
  - `psel=0`, `penable=0`, `paddr=0`, `pwrite=0`, `pwdata=0`;
  - `hreadyout=1`, `hresp=0`, `hrdata=0`;
  - counter 0.
- **Reset mid-transfer** aborts without an ERROR response; outputs return to reset values the cycle after `hreset` is sampled high.
- **Latency:**
  - With `pready=1` on the first ACCESS cycle: T0 address, T1 SETUP (`hreadyout=0`), T2 ACCESS completes (`hreadyout=1`). One wait state.
  - Each cycle of `pready=0` adds one wait state.
- **Back-to-back:** a transfer accepted in a completing ACCESS or ERR2 cycle enters SETUP at the next cycle, with no IDLE bubble.
- **Decode miss:** T1 ERR1, T2 ERR2. No APB activity.
- **`pslverr`:** completion cycle (ACCESS, `pready=1`), then ERR1, then ERR2. Three data-phase cycles after SETUP.
- **Timeout:** ERR1 begins `TIMEOUT` cycles after SETUP+1.
- **Width rules:** the counter is `$clog2(TIMEOUT+1)` bits and saturates. `paddr` is a full `ADDR_W`, with no truncation.

## Test plan
- **Write hit:** `haddr=0x4000_3004`, `hwdata=0xDEADBEEF`, `pready[3]=1` → `psel=12'h008`, `paddr=0x4000_3004`, `pwdata=0xDEADBEEF`, `penable` in T2, `hreadyout` low exactly 1 cycle, `hresp=0`.
- **Read with wait states:** read `0x4000_B010`, `pready[11]` low 3 cycles, `prdata[11]=0x1234_5678` → 4 wait states, `hrdata=0x1234_5678` in the completing cycle.
- **Error responses:** `pslverr[5]=1` on completion of a write to `0x4000_5000` → ERR1/ERR2 with `hresp=1` on 2 cycles, `hreadyout` 0 then 1. Access to `0x4000_C000` (idx 12) or `0x5000_0000` → no `psel`, immediate 2-cycle ERROR.
- **Timeout:** with `TIMEOUT=4`, `pready[0]` held 0 → `psel`/`penable` dropped after 4 ACCESS cycles, then ERROR response. With `TIMEOUT=0` the bridge waits indefinitely.
- **Back-to-back:** NONSEQ write to slave 1 then SEQ read from slave 2 issued in the completing cycle → SETUP for slave 2 in the next cycle, no IDLE gap, `psel` never multi-hot.
- **Reset mid-ACCESS:** assert `hreset` for 1 cycle in ACCESS → next cycle all outputs at reset values, `hresp=0`, and a fresh transfer works normally.

Source files
------------

// File: rtl/apb_bridge_gen.sv
// rtl/apb_bridge_gen.sv - AHB-Lite to APB bridge with decode, error response and pready timeout
module apb_bridge_gen #(
  parameter int                NUM_SLV   = 12,
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                SLV_BITS  = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h4000_0000,
  parameter int                TIMEOUT   = 256
) (
  input  logic                      hclk,
  input  logic                      hreset,
  input  logic                      hsel,
  input  logic [ADDR_W-1:0]         haddr,
  input  logic [1:0]                htrans,
  input  logic                      hwrite,
  input  logic                      hready,
  input  logic [DATA_W-1:0]         hwdata,
  output logic [DATA_W-1:0]         hrdata,
  output logic                      hreadyout,
  output logic                      hresp,
  output logic [NUM_SLV-1:0]        psel,
  output logic [ADDR_W-1:0]         paddr,
  output logic                      penable,
  output logic                      pwrite,
  output logic [DATA_W-1:0]         pwdata,
  input  logic [NUM_SLV*DATA_W-1:0] prdata,
  input  logic [NUM_SLV-1:0]        pready,
  input  logic [NUM_SLV-1:0]        pslverr
);

  localparam int IDX_W   = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int TOP_LSB = SLV_BITS + IDX_W;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   idx_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [ADDR_W-1:0]  paddr_q;
  logic               pwrite_q;
  logic [DATA_W-1:0]  pwdata_q;

  logic               xfer_valid;
  logic               addr_hit;
  logic [IDX_W-1:0]   h_idx;
  logic               load;
  logic               sel_active;
  logic               pready_sel;
  logic               pslverr_sel;
  logic [DATA_W-1:0]  prdata_sel;
  logic               to_hit;

  // Only NONSEQ/SEQ transfers on a selected, ready bus are accepted
  assign xfer_valid = hsel & hready & ((htrans == 2'b10) | (htrans == 2'b11));
  assign h_idx      = haddr[SLV_BITS +: IDX_W];
  assign addr_hit   = (haddr[ADDR_W-1:TOP_LSB] == BASE_ADDR[ADDR_W-1:TOP_LSB]) &&
                      ({1'b0, h_idx} < (IDX_W+1)'(NUM_SLV));
  assign to_hit     = (TIMEOUT != 0) && (cnt_q == TO_LAST);

  assign paddr  = paddr_q;
  assign pwrite = pwrite_q;

  // Fan out the select and pick the addressed slave's return signals
  always_comb begin
    psel        = '0;
    pready_sel  = 1'b0;
    pslverr_sel = 1'b0;
    prdata_sel  = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (idx_q == IDX_W'(i)) begin
        psel[i]     = sel_active;
        pready_sel  = pready[i];
        pslverr_sel = pslverr[i];
        prdata_sel  = prdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next-state and AHB/APB output decode
  always_comb begin
    state_nxt  = state;
    hreadyout  = 1'b1;
    hresp      = 1'b0;
    hrdata     = '0;
    sel_active = 1'b0;
    penable    = 1'b0;
    pwdata     = '0;
    load       = 1'b0;
    case (state)
      S_IDLE: begin
        if (xfer_valid) begin
          load      = 1'b1;
          state_nxt = addr_hit ? S_SETUP : S_ERR1;
        end
      end
      S_SETUP: begin
        sel_active = 1'b1;
        hreadyout  = 1'b0;
        pwdata     = pwrite_q ? hwdata : '0;
        state_nxt  = S_ACCESS;
      end
      S_ACCESS: begin
        sel_active = 1'b1;
        penable    = 1'b1;
        pwdata     = pwrite_q ? pwdata_q : '0;
        if (pready_sel) begin
          if (pslverr_sel) begin
            hreadyout = 1'b0;
            state_nxt = S_ERR1;
          end else begin
            hreadyout = 1'b1;
            if (!pwrite_q) hrdata = prdata_sel;
            if (xfer_valid) begin
              load      = 1'b1;
              state_nxt = addr_hit ? S_SETUP : S_ERR1;
            end else begin
              state_nxt = S_IDLE;
            end
          end
        end else begin
          hreadyout = 1'b0;
          if (to_hit) state_nxt = S_ERR1;
        end
      end
      S_ERR1: begin
        hresp     = 1'b1;
        hreadyout = 1'b0;
        state_nxt = S_ERR2;
      end
      S_ERR2: begin
        hresp = 1'b1;
        if (xfer_valid) begin
          load      = 1'b1;
          state_nxt = addr_hit ? S_SETUP : S_ERR1;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge hclk) begin
    if (hreset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Address-phase capture, write data hold and ACCESS wait counter
  always_ff @(posedge hclk) begin
    if (hreset) begin
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      idx_q    <= '0;
      pwdata_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (load) begin
        paddr_q  <= haddr;
        pwrite_q <= hwrite;
        idx_q    <= h_idx;
      end
      if (state == S_SETUP) begin
        pwdata_q <= hwdata;
        cnt_q    <= '0;
      end else if (state == S_ACCESS && !pready_sel && cnt_q != CNT_MAX) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule
